// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file: bus widths, zero word,
// enable encodings and the reset compare level.
package wb_regfile_pkg;

  localparam int DataWidth  = 32;
  localparam int RegNumLog2 = 5;
  localparam int RegNum     = 32;

  typedef logic [DataWidth-1:0]  RegBus;
  typedef logic [RegNumLog2-1:0] RegAddrBus;

  localparam RegBus     ZeroWord     = 32'h0000_0000;
  localparam RegAddrBus NOPRegAddr   = 5'b00000;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      ReadEnable   = 1'b1;
  localparam logic      ReadDisable  = 1'b0;
  localparam logic      RstActiveLow = 1'b0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write bundle plus the ID/EX read ports of the register file.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DataWidth,
  parameter int ADDR_W = RegNumLog2
);

  logic              wb_wreg;
  logic [ADDR_W-1:0] wb_wd;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );

endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair with write-through bypass; both halves always update together.
module hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DataWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q, lo_q, hi_d, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we_i == WriteEnable) begin
      hi_d = hi_i;
      lo_d = lo_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActiveLow) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Next-state doubles as the bypassed read value.
  assign hi_o = (rst == RstActiveLow) ? '0 : hi_d;
  assign lo_o = (rst == RstActiveLow) ? '0 : lo_d;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: 32 GPRs with two bypassed read ports and
// the HI/LO pair, committing the registered MEM/WB bundle.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W  = DataWidth,
  parameter int ADDR_W  = RegNumLog2,
  parameter int REG_NUM = RegNum
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [REG_NUM];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActiveLow) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wb_wreg == WriteEnable && bus.wb_wd != '0) begin
      regs_q[bus.wb_wd] <= bus.wb_wdata;
    end
  end

  // $0 wins over the bypass, so a write aimed at $0 never leaks to a reader.
  function automatic logic [DATA_W-1:0] readPort(
    input logic              rstN,
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic              wreg,
    input logic [ADDR_W-1:0] wd,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] value;
    value = '0;
    if (rstN != RstActiveLow && en == ReadEnable && addr != '0) begin
      if (wreg == WriteEnable && wd == addr) value = wdata;
      else                                  value = stored;
    end
    return value;
  endfunction

  assign bus.rdata1 = readPort(rst, bus.re1, bus.raddr1, bus.wb_wreg, bus.wb_wd,
                               bus.wb_wdata, regs_q[bus.raddr1]);
  assign bus.rdata2 = readPort(rst, bus.re2, bus.raddr2, bus.wb_wreg, bus.wb_wd,
                               bus.wb_wdata, regs_q[bus.raddr2]);

  hilo_reg #(.DATA_W(DATA_W)) uHilo (
    .clk  (clk),
    .rst  (rst),
    .we_i (bus.wb_whilo),
    .hi_i (bus.wb_hi),
    .lo_i (bus.wb_lo),
    .hi_o (bus.hi_o),
    .lo_o (bus.lo_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, $0, bypass, HI/LO,
// full sweep and concurrent GPR/HI-LO writes.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wreg, input logic [4:0] wd,
                               input logic [31:0] wdata);
    bus.wb_wreg  = wreg;
    bus.wb_wd    = wd;
    bus.wb_wdata = wdata;
  endtask

  initial begin
    logic [31:0] expWord;
    testsRun    = 0;
    testsFailed = 0;
    rst          = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0);
    bus.wb_whilo = 1'b0;
    bus.wb_hi    = 32'h0;
    bus.wb_lo    = 32'h0;
    bus.re1      = 1'b0;
    bus.raddr1   = 5'd0;
    bus.re2      = 1'b0;
    bus.raddr2   = 5'd0;

    // Outputs forced to zero while in reset, even with enables and bypass requests
    #2;
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    applyStimulus(1'b1, 5'd5, 32'h1111_1111);
    bus.wb_whilo = 1'b1; bus.wb_hi = 32'h5; bus.wb_lo = 32'h6;
    #1;
    checkOutput("reset_rdata1", bus.rdata1, 32'h0);
    checkOutput("reset_hi", bus.hi_o, 32'h0);
    checkOutput("reset_lo", bus.lo_o, 32'h0);
    tick();
    checkOutput("reset_write_discarded", bus.rdata1, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0);
    bus.wb_whilo = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("post_reset_reg5", bus.rdata1, 32'h0);
    checkOutput("post_reset_hi", bus.hi_o, 32'h0);

    // Write reg5 then pull reset mid-run
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("reg5_written", bus.rdata1, 32'hDEAD_BEEF);
    rst = 1'b0;
    #1;
    checkOutput("reset_async_rdata1", bus.rdata1, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("reg5_cleared", bus.rdata1, 32'h0);

    // Write in flight when reset falls is lost
    applyStimulus(1'b1, 5'd9, 32'h9999_0000);
    rst = 1'b0;
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    bus.raddr1 = 5'd9;
    #1;
    checkOutput("inflight_write_lost", bus.rdata1, 32'h0);

    // $0 is never written and never bypassed
    bus.raddr1 = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    checkOutput("r0_bypass", bus.rdata1, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("r0_after_write", bus.rdata1, 32'h0);

    // Write then read on both ports, then disable port 2
    applyStimulus(1'b1, 5'd7, 32'h1234_5678);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0);
    bus.re1 = 1'b1; bus.raddr1 = 5'd7;
    bus.re2 = 1'b1; bus.raddr2 = 5'd7;
    #1;
    checkOutput("reg7_port1", bus.rdata1, 32'h1234_5678);
    checkOutput("reg7_port2", bus.rdata2, 32'h1234_5678);
    bus.re2 = 1'b0;
    #1;
    checkOutput("port2_disabled", bus.rdata2, 32'h0);
    bus.re1 = 1'b0;
    #1;
    checkOutput("port1_disabled", bus.rdata1, 32'h0);
    bus.re1 = 1'b1;

    // Same-cycle bypass versus stored value
    applyStimulus(1'b1, 5'd3, 32'hAAAA_0000);
    tick();
    bus.raddr1 = 5'd3;
    applyStimulus(1'b1, 5'd3, 32'h0000_5555);
    #1;
    checkOutput("bypass_port1", bus.rdata1, 32'h0000_5555);
    applyStimulus(1'b0, 5'd3, 32'h0000_5555);
    #1;
    checkOutput("no_bypass_when_disabled", bus.rdata1, 32'hAAAA_0000);
    tick();
    checkOutput("reg3_kept", bus.rdata1, 32'hAAAA_0000);

    // HI/LO bypass, commit, and hold
    bus.wb_whilo = 1'b1; bus.wb_hi = 32'h1; bus.wb_lo = 32'h2;
    #1;
    checkOutput("hi_bypass", bus.hi_o, 32'h1);
    checkOutput("lo_bypass", bus.lo_o, 32'h2);
    tick();
    bus.wb_whilo = 1'b0;
    #1;
    checkOutput("hi_held", bus.hi_o, 32'h1);
    checkOutput("lo_held", bus.lo_o, 32'h2);
    bus.wb_hi = 32'h9;
    tick();
    checkOutput("hi_ignores_data", bus.hi_o, 32'h1);
    checkOutput("lo_ignores_data", bus.lo_o, 32'h2);

    // Sweep all registers through both ports
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i) * 32'h0101_0101);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0);
    bus.re1 = 1'b1; bus.re2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.raddr1 = 5'(i);
      bus.raddr2 = 5'(31 - i);
      expWord = 32'(i) * 32'h0101_0101;
      #1;
      checkOutput($sformatf("sweep_p1_r%0d", i), bus.rdata1, expWord);
      expWord = 32'(31 - i) * 32'h0101_0101;
      checkOutput($sformatf("sweep_p2_r%0d", 31 - i), bus.rdata2, expWord);
    end

    // Concurrent GPR and HI/LO writes with reads of the written and a neighbour register
    applyStimulus(1'b1, 5'd31, 32'h0000_CAFE);
    bus.wb_whilo = 1'b1; bus.wb_hi = 32'h3; bus.wb_lo = 32'h4;
    bus.raddr1 = 5'd31; bus.raddr2 = 5'd30;
    #1;
    checkOutput("conc_bypass_r31", bus.rdata1, 32'h0000_CAFE);
    checkOutput("conc_r30", bus.rdata2, 32'h1E1E_1E1E);
    checkOutput("conc_hi_bypass", bus.hi_o, 32'h3);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0);
    bus.wb_whilo = 1'b0;
    #1;
    checkOutput("conc_r31_committed", bus.rdata1, 32'h0000_CAFE);
    checkOutput("conc_r30_unchanged", bus.rdata2, 32'h1E1E_1E1E);
    checkOutput("conc_hi_committed", bus.hi_o, 32'h3);
    checkOutput("conc_lo_committed", bus.lo_o, 32'h4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB interface: consumes the registered wb_* bundle and commits it to architectural state.
- Holds the 32x32 general register file and the HI/LO pair.
- Serves two GPR read ports to ID and HI/LO read to EX, with same-cycle write-to-read bypass, so the pipeline needs no extra WB-stage forwarding path.

Parameters:
- DATA_W, 32, width of GPR, HI and LO.
- ADDR_W, 5, GPR address width.
- REG_NUM, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst==0 resets).
- wb_wreg  in  1  GPR write enable from MEM/WB.
- wb_wd  in  ADDR_W  GPR write address.
- wb_wdata  in  DATA_W  GPR write data.
- wb_whilo  in  1  HI/LO write enable.
- wb_hi  in  DATA_W  HI write data.
- wb_lo  in  DATA_W  LO write data.
- re1  in  1  read enable, port 1.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1.
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2.
- hi_o  out  DATA_W  current HI, bypassed.
- lo_o  out  DATA_W  current LO, bypassed.

Behaviour:
- Reset (rst==0, asynchronous):
  - All REG_NUM GPRs and HI/LO clear to ZeroWord immediately.
  - rdata1/2, hi_o and lo_o are forced to ZeroWord while reset is asserted.
  - Writes presented during reset are discarded.
  - Deassertion is sampled by flops synchronously; the first write commits on the first rising edge with rst==1.
- GPR write: on posedge clk, if rst==1, wb_wreg==1 and wb_wd!=0, then reg[wb_wd] <= wb_wdata.
- $0: writes to address 0 are ignored; $0 always reads ZeroWord, including through the bypass.
- HI/LO write: on posedge clk, if rst==1 and wb_whilo==1, HI <= wb_hi and LO <= wb_lo. Both registers always update together.
- GPR read: combinational, zero latency. Per port n, in priority order:
  1. rst==0 -> ZeroWord
  2. ren==0 -> ZeroWord
  3. raddrn==0 -> ZeroWord
  4. wb_wreg==1 and wb_wd==raddrn -> wb_wdata (bypass)
  5. else reg[raddrn]
- HI/LO read: combinational.
  - rst==0 -> ZeroWord.
  - wb_whilo==1 -> wb_hi / wb_lo (bypass).
  - Else the stored values.
- Simultaneous events:
  - Both ports may read the same address; each is served independently, and both see the bypass.
  - A GPR write and a HI/LO write in the same cycle are independent.
- Stall/flush: no stall input. A stalled or flushed MEM/WB presents wb_wreg=0 and wb_whilo=0, so no write occurs and read values hold.
- X-safety: when the matching write enable is 0, the address and data inputs must not affect any output or state.
- Reset mid-operation: an in-flight write on the edge where rst falls is lost; state ends at zero.
- No internal FSM. Sequential state is the GPR array plus HI/LO. No clock gating.

Decomposition:
- Shared defines (defines.v): RegAddrBus, RegBus, RegNum, RegNumLog2, ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, ReadEnable/ReadDisable.
- Add one new constant, RstActiveLow (1'b0), for this block's reset compare.
- Sub-module hilo_reg holds the HI/LO flops and their bypass mux, instantiated once. The GPR array and read muxes stay in wb_regfile.

Test Plan:
- Reset and $0:
  - Assert rst=0 mid-run after writing reg[5]=32'hDEAD_BEEF -> rdata1=0 immediately.
  - After release, re1=1, raddr1=5 -> 0.
  - wb_wreg=1, wb_wd=0, wb_wdata=32'hFFFF_FFFF, raddr1=0 -> rdata1=0 during and after the edge.
- Write then read:
  - Write reg[7]=32'h1234_5678.
  - Next cycle, re1=re2=1, raddr1=raddr2=7 -> both 32'h1234_5678.
  - re2=0 -> rdata2=0.
- Same-cycle bypass:
  - reg[3] holds 32'hAAAA_0000. Present wb_wreg=1, wb_wd=3, wb_wdata=32'h0000_5555 with raddr1=3 -> rdata1=32'h0000_5555 before the edge.
  - wb_wreg=0 with the same address/data -> rdata1=32'hAAAA_0000.
- HI/LO:
  - wb_whilo=1, wb_hi=32'h1, wb_lo=32'h2 -> hi_o=1, lo_o=2 combinationally; held after the edge with wb_whilo=0.
  - Next, wb_whilo=0 with wb_hi=32'h9 -> hi_o stays 1.
- Sweep: write reg[i]=i*32'h0101_0101 for i=1..31, then read all via both ports -> exact match, and reg[0]=0.
- Concurrency: in one cycle, write GPR 31=32'hCAFE and HI/LO=(3,4) -> both committed.
  - In the same cycle, raddr1=31 and raddr2=30 -> rdata1=32'hCAFE and rdata2 unchanged.
